// File: rtl/lsu_subword.sv
// Load/store unit between the RV32I datapath and a word-only data memory: sub-word loads with
// extension, SB/SH as a two-cycle read-modify-write. Optional build macro: MISALIGN_TRAP_EN.
module lsu_subword #(
  parameter int ADDR_W      = 32,
  parameter int MEM_IDX_LSB = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  output logic [31:0]       load_data,
  output logic              stall,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
`ifdef MISALIGN_TRAP_EN
  ,
  output logic              misalign
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD_RESP, STORE_MERGE} state_t;

  state_t      state_q, state_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  f3_q, f3_d;
  logic [15:0] sdata_q, sdata_d;

  logic       req;
  logic       unsup;
  logic       bad_align;
  logic [1:0] size;

  assign mem_addr = {addr[ADDR_W-1:MEM_IDX_LSB], {MEM_IDX_LSB{1'b0}}};

  assign req   = MemRead | MemWrite;
  assign unsup = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
  assign size  = funct3[1:0];

`ifdef MISALIGN_TRAP_EN
  assign bad_align = !unsup && (((size == 2'b01) && addr[0]) ||
                                ((size == 2'b10) && (addr[1:0] != 2'b00)));
  assign misalign  = !rst && (state_q == IDLE) && req && bad_align;
`else
  assign bad_align = 1'b0;
`endif

  // Lane select plus sign/zero extension; W returns the word unchanged.
  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] off,
                                          input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'd0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] word, input logic [1:0] off,
                                        input logic [1:0] sz, input logic [15:0] sd);
    logic [31:0] r;
    r = word;
    if (sz == 2'b00) begin
      case (off)
        2'd0:    r[7:0]   = sd[7:0];
        2'd1:    r[15:8]  = sd[7:0];
        2'd2:    r[23:16] = sd[7:0];
        default: r[31:24] = sd[7:0];
      endcase
    end else if (off[1]) begin
      r[31:16] = sd;
    end else begin
      r[15:0] = sd;
    end
    return r;
  endfunction

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d   = state_q;
    word_d    = word_q;
    off_d     = off_q;
    f3_d      = f3_q;
    sdata_d   = sdata_q;
    load_data = '0;
    stall     = 1'b0;
    done      = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    // Reset also masks outputs, so an access aborted mid-flight never writes.
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (req) begin
            if (unsup || bad_align) begin
              done = 1'b1;
            end else if (MemWrite && (size == 2'b10)) begin
              mem_we    = 1'b1;
              mem_wdata = store_data;
              done      = 1'b1;
            end else begin
              mem_re  = 1'b1;
              stall   = 1'b1;
              word_d  = mem_rdata;
              off_d   = addr[1:0];
              f3_d    = funct3;
              sdata_d = store_data[15:0];
              state_d = MemWrite ? STORE_MERGE : LOAD_RESP;
            end
          end
        end
        LOAD_RESP: begin
          done      = 1'b1;
          load_data = extract(word_q, off_q, f3_q);
          state_d   = IDLE;
        end
        STORE_MERGE: begin
          done      = 1'b1;
          mem_we    = 1'b1;
          mem_wdata = merge(word_q, off_q, f3_q[1:0], sdata_q);
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      off_q   <= '0;
      f3_q    <= '0;
      sdata_q <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      sdata_q <= sdata_d;
    end
  end

endmodule

// File: tb/tb_lsu_subword.sv
// Scoreboard bench for lsu_subword: directed accesses push expected responses, a monitor
// pops and compares on every done cycle. Build with MISALIGN_TRAP_EN to cover the trap.
module tb_lsu_subword;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead, MemWrite;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic [31:0] load_data;
  logic        stall, done, mem_re, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef MISALIGN_TRAP_EN
  logic        misalign;
`endif

  lsu_subword #(.ADDR_W(32), .MEM_IDX_LSB(2)) dut (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .funct3(funct3),
    .addr(addr), .store_data(store_data), .load_data(load_data), .stall(stall),
    .done(done), .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef MISALIGN_TRAP_EN
    , .misalign(misalign)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:63];
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;

  typedef struct {
    logic [31:0] ld;
    logic        we;
    logic [31:0] wd;
    logic        mis;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 expected no response at %0t", $time);
      end else begin
        mon_e = sb_q.pop_front();
        check("load_data", load_data, mon_e.ld);
        check("mem_we", {31'd0, mem_we}, {31'd0, mon_e.we});
        if (mon_e.we) check("mem_wdata", mem_wdata, mon_e.wd);
`ifdef MISALIGN_TRAP_EN
        check("misalign", {31'd0, misalign}, {31'd0, mon_e.mis});
`endif
      end
    end
  end

  task automatic access(input string nm, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd, input logic [31:0] ld,
                        input logic we, input logic [31:0] wd, input logic mis, input int lat);
    exp_t e;
    bit   got;
    e.ld = ld; e.we = we; e.wd = wd; e.mis = mis;
    sb_q.push_back(e);
    MemRead = rd; MemWrite = wr; funct3 = f3; addr = a; store_data = sd;
    got = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        check({nm, " latency"}, c, lat);
        check({nm, " stall@done"}, {31'd0, stall}, 32'd0);
        check({nm, " mem_re@done"}, {31'd0, mem_re}, 32'd0);
        break;
      end
      if (c == 0) begin
        check({nm, " stall@c0"}, {31'd0, stall}, 32'd1);
        check({nm, " mem_re@c0"}, {31'd0, mem_re}, 32'd1);
      end
      @(posedge clk); #1;
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s timeout: got no done expected done within 4 cycles", nm);
      sb_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    MemRead = 1'b0; MemWrite = 1'b0;
    @(posedge clk); #1;
  endtask

  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100,
                         F_HU = 3'b101, F_BAD = 3'b011;

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    mem[4] = 32'hA1B2C3D4;
    mem[5] = 32'h7F801234;
    rst = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; funct3 = F_W; addr = 32'h10; store_data = '0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst load_data", load_data, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst stall", {31'd0, stall}, 32'd0);
    check("rst mem_re", {31'd0, mem_re}, 32'd0);
    check("rst mem_we", {31'd0, mem_we}, 32'd0);
    check("rst mem_wdata", mem_wdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle();

    // Loads across lanes and extension modes
    access("LB 13",  1, 0, F_B,  32'h13, 0, 32'hFFFFFFA1, 0, 0, 0, 1);
    access("LBU 13", 1, 0, F_BU, 32'h13, 0, 32'h000000A1, 0, 0, 0, 1);
    access("LH 12",  1, 0, F_H,  32'h12, 0, 32'hFFFFA1B2, 0, 0, 0, 1);
    access("LHU 10", 1, 0, F_HU, 32'h10, 0, 32'h0000C3D4, 0, 0, 0, 1);
    access("LW 10",  1, 0, F_W,  32'h10, 0, 32'hA1B2C3D4, 0, 0, 0, 1);
    access("LB 10",  1, 0, F_B,  32'h10, 0, 32'hFFFFFFD4, 0, 0, 0, 1);
    access("LB 15",  1, 0, F_B,  32'h15, 0, 32'h00000012, 0, 0, 0, 1);
    access("LH 16",  1, 0, F_H,  32'h16, 0, 32'h00007F80, 0, 0, 0, 1);
    access("LB 16",  1, 0, F_B,  32'h16, 0, 32'hFFFFFF80, 0, 0, 0, 1);

    // Sub-word and word stores, read back
    access("SB 11",  0, 1, F_B,  32'h11, 32'h123456EE, 0, 1, 32'hA1B2EED4, 0, 1);
    access("LW 10b", 1, 0, F_W,  32'h10, 0, 32'hA1B2EED4, 0, 0, 0, 1);
    access("SW 10",  0, 1, F_W,  32'h10, 32'h12345678, 0, 1, 32'h12345678, 0, 0);
    access("SH 12",  0, 1, F_H,  32'h12, 32'h0000BEEF, 0, 1, 32'hBEEF5678, 0, 1);
    access("LW 10c", 1, 0, F_W,  32'h10, 0, 32'hBEEF5678, 0, 0, 0, 1);

    // Reset during STORE_MERGE must not write
    MemRead = 1'b0; MemWrite = 1'b1; funct3 = F_H; addr = 32'h10; store_data = 32'h0000CAFE;
    @(negedge clk);
    check("abort stall@c0", {31'd0, stall}, 32'd1);
    check("abort mem_re@c0", {31'd0, mem_re}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("abort mem_we", {31'd0, mem_we}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; MemWrite = 1'b0;
    @(negedge clk);
    check("post-abort done", {31'd0, done}, 32'd0);
    check("post-abort stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    access("LW 10d", 1, 0, F_W,  32'h10, 0, 32'hBEEF5678, 0, 0, 0, 1);

    // Read+write together is a store; unsupported funct3 completes with no access
    access("RW SW 14", 1, 1, F_W, 32'h14, 32'hDEADBEEF, 0, 1, 32'hDEADBEEF, 0, 0);
    access("LW 14",  1, 0, F_W,  32'h14, 0, 32'hDEADBEEF, 0, 0, 0, 1);
    access("SB 17",  0, 1, F_B,  32'h17, 32'h000000AA, 0, 1, 32'hAAADBEEF, 0, 1);
    access("LBU 17", 1, 0, F_BU, 32'h17, 0, 32'h000000AA, 0, 0, 0, 1);
    access("BAD f3", 1, 0, F_BAD, 32'h10, 0, 32'd0, 0, 0, 0, 0);

`ifdef MISALIGN_TRAP_EN
    access("LW 12 trap", 1, 0, F_W, 32'h12, 0, 32'd0, 0, 0, 1, 0);
    access("SH 11 trap", 0, 1, F_H, 32'h11, 32'h1111, 0, 0, 0, 1, 0);
    access("LW 10e", 1, 0, F_W, 32'h10, 0, 32'hBEEF5678, 0, 0, 0, 1);
`else
    access("LW 12", 1, 0, F_W, 32'h12, 0, 32'hBEEF5678, 0, 0, 0, 1);
`endif
    idle();
    idle();

    if (sb_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard drain: got %0d pending expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
